// File: rtl/uart_cmd_assembler.sv
// Packs CMD_BYTES received UART bytes (first byte in the MSBs) into one command word.
// Optional inter-byte timeout guarded by CMD_TIMEOUT_EN; cmd_err is tied 0 without it.
module uart_cmd_assembler #(
   parameter int CMD_BYTES      = 3,
   parameter int TIMEOUT_CYCLES = 500000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             rx_data,
   input  logic                   rdy,
   output logic                   clr_rdy,
   output logic [8*CMD_BYTES-1:0] cmd,
   output logic                   cmd_rdy,
   input  logic                   clr_cmd_rdy,
   output logic                   cmd_err
);

   localparam int W  = 8 * CMD_BYTES;
   localparam int CW = $clog2(CMD_BYTES + 1);
   localparam logic [CW-1:0] LAST = CW'(CMD_BYTES - 1);

   if (CMD_BYTES < 2) begin : g_bad_bytes
      $error("CMD_BYTES must be at least 2");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] byte_cnt, byte_cnt_nxt;
   logic [W-1:0]  shift_reg, shift_nxt, cmd_nxt;
   logic          cmd_rdy_nxt;
   logic          take;
   logic          done;
   logic          tmo;

   // clr_rdy masks the cycle before the receiver drops rdy
   assign take = rdy & ~clr_rdy & (state != HOLD);
   assign done = take & (state == ACCUM) & (byte_cnt == LAST);

`ifdef CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tcnt;

   assign tmo = (state == ACCUM) & ~take & (tcnt == TLAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt    <= '0;
         cmd_err <= 1'b0;
      end else begin
         cmd_err <= tmo;
         if (take || tmo || state != ACCUM) tcnt <= '0;
         else                               tcnt <= tcnt + TW'(1);
      end
   end
`else
   assign tmo     = 1'b0;
   assign cmd_err = 1'b0;
`endif

   always_comb begin
      state_nxt    = state;
      byte_cnt_nxt = byte_cnt;
      shift_nxt    = shift_reg;
      cmd_nxt      = cmd;
      cmd_rdy_nxt  = cmd_rdy;
      if (take) begin
         shift_nxt    = {shift_reg[W-9:0], rx_data};
         byte_cnt_nxt = byte_cnt + CW'(1);
      end
      unique case (state)
         IDLE: begin
            if (take) state_nxt = ACCUM;
         end
         ACCUM: begin
            if (tmo) begin
               state_nxt    = IDLE;
               byte_cnt_nxt = '0;
               shift_nxt    = '0;
            end else if (done) begin
               state_nxt    = HOLD;
               cmd_nxt      = {shift_reg[W-9:0], rx_data};
               cmd_rdy_nxt  = 1'b1;
               byte_cnt_nxt = '0;
            end
         end
         HOLD: begin
            if (clr_cmd_rdy) begin
               cmd_rdy_nxt = 1'b0;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         byte_cnt  <= '0;
         shift_reg <= '0;
         cmd       <= '0;
         cmd_rdy   <= 1'b0;
         clr_rdy   <= 1'b0;
      end else begin
         state     <= state_nxt;
         byte_cnt  <= byte_cnt_nxt;
         shift_reg <= shift_nxt;
         cmd       <= cmd_nxt;
         cmd_rdy   <= cmd_rdy_nxt;
         clr_rdy   <= take;
      end
   end

endmodule
